// File: rtl/dh_pkg.sv
// Shared types and constants for the Diffie-Hellman key-verification controller.
package dh_pkg;

  localparam int unsigned MSG_W = 48;

  localparam logic [MSG_W-1:0] ACCEPT_MSG = 48'h414343455054;  // "ACCEPT"
  localparam logic [MSG_W-1:0] REJECT_MSG = 48'h52454A454354;  // "REJECT"

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  // Stage index width; a single-check controller still carries a 1-bit index.
  function automatic int unsigned stage_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dh_key_check_ctrl_if.sv
// Verdict handshake and result bus between the key-comparison logic and the controller.
interface dh_key_check_ctrl_if #(
  parameter int unsigned NUM_CHECKS = 2
);
  import dh_pkg::*;

  localparam int unsigned SW = stage_w(NUM_CHECKS);

  logic             start;
  logic             check_valid;
  logic             check_pass;
  logic [MSG_W-1:0] out;
  logic             busy;
  logic             done;
  logic             accept;
  logic             timeout;
  logic [SW-1:0]    stage_idx;

  modport master (
    output start, check_valid, check_pass,
    input  out, busy, done, accept, timeout, stage_idx
  );

  modport slave (
    input  start, check_valid, check_pass,
    output out, busy, done, accept, timeout, stage_idx
  );

endinterface

// File: rtl/dh_stage_timer.sv
// Per-stage wait counter; expire_c is high while the count sits at its last allowed value.
module dh_stage_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned TW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          ARMED = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  // Holds at LAST so the count never runs past the expiry point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (ARMED && enable && !expire_c) begin
      count <= count + TW'(1);
    end
  end

  assign expire_c = ARMED && (count == LAST);

endmodule

// File: rtl/dh_key_check_ctrl.sv
// Sequences NUM_CHECKS ordered verdicts with a per-stage timeout and reports ACCEPT/REJECT.
module dh_key_check_ctrl
  import dh_pkg::*;
#(
  parameter int unsigned NUM_CHECKS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  dh_key_check_ctrl_if.slave bus
);

  localparam int unsigned SW = stage_w(NUM_CHECKS);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_CHECKS - 1);

  state_t           state;
  logic [SW-1:0]    stage;
  logic [MSG_W-1:0] msg_q;
  logic             busy_q;
  logic             done_q;
  logic             accept_q;
  logic             timeout_q;

  logic timer_clear_c;
  logic timer_en_c;
  logic expire_c;

  // Timer runs only while waiting without a verdict; anything else restarts it.
  assign timer_clear_c = (state != ST_WAIT) || bus.check_valid;
  assign timer_en_c    = (state == ST_WAIT) && !bus.check_valid;

  dh_stage_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear_c),
    .enable   (timer_en_c),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      stage     <= '0;
      msg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      accept_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_RESULT: begin
          if (bus.start) begin
            state     <= ST_WAIT;
            stage     <= '0;
            msg_q     <= '0;
            busy_q    <= 1'b1;
            accept_q  <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          // A verdict in the same cycle as expiry wins over the timeout.
          if (bus.check_valid) begin
            if (!bus.check_pass) begin
              state     <= ST_RESULT;
              msg_q     <= REJECT_MSG;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              accept_q  <= 1'b0;
              timeout_q <= 1'b0;
            end else if (stage == LAST_STAGE) begin
              state     <= ST_RESULT;
              msg_q     <= ACCEPT_MSG;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              accept_q  <= 1'b1;
              timeout_q <= 1'b0;
            end else begin
              stage <= stage + SW'(1);
            end
          end else if (expire_c) begin
            state     <= ST_RESULT;
            msg_q     <= REJECT_MSG;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            accept_q  <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          stage     <= '0;
          msg_q     <= '0;
          busy_q    <= 1'b0;
          accept_q  <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = msg_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.accept    = accept_q;
  assign bus.timeout   = timeout_q;
  assign bus.stage_idx = stage;

endmodule

// File: tb/tb_dh_key_check_ctrl.sv
// Bench for dh_key_check_ctrl: two configurations driven in lockstep against a behavioural model.
module tb_dh_key_check_ctrl;

  localparam logic [47:0] ACC = 48'h414343455054;
  localparam logic [47:0] REJ = 48'h52454A454354;

  logic clk;
  logic rst;
  logic s, v, p;

  int total  = 0;
  int passed = 0;

  dh_key_check_ctrl_if #(.NUM_CHECKS(4)) ifa ();
  dh_key_check_ctrl_if #(.NUM_CHECKS(2)) ifb ();

  assign ifa.start = s;  assign ifa.check_valid = v;  assign ifa.check_pass = p;
  assign ifb.start = s;  assign ifb.check_valid = v;  assign ifb.check_pass = p;

  dh_key_check_ctrl #(.NUM_CHECKS(4), .TIMEOUT_CYCLES(4)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  dh_key_check_ctrl #(.NUM_CHECKS(2), .TIMEOUT_CYCLES(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 waiting, 2 result; idle counts cycles spent in the current stage.
  typedef struct {
    int          mode;
    int          stage;
    int          idle;
    logic [47:0] out;
    bit          busy, done, accept, tmo;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t fresh();
    mdl_t r;
    r.mode = 0; r.stage = 0; r.idle = 0; r.out = '0;
    r.busy = 0; r.done = 0; r.accept = 0; r.tmo = 0;
    return r;
  endfunction

  function automatic mdl_t conclude(mdl_t m, bit acc, bit to);
    mdl_t r = m;
    r.mode = 2; r.busy = 0; r.done = 1; r.accept = acc; r.tmo = to;
    r.out = acc ? ACC : REJ;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, bit st, bit cv, bit cp, int n, int t);
    mdl_t r = m;
    r.done = 0;
    if (m.mode != 1) begin
      if (st) begin
        r = fresh();
        r.mode = 1;
        r.busy = 1;
      end
    end else if (cv) begin
      if (!cp)                 r = conclude(r, 0, 0);
      else if (m.stage == n-1) r = conclude(r, 1, 0);
      else begin
        r.stage = m.stage + 1;
        r.idle  = 0;
      end
    end else if (t != 0 && m.idle + 1 == t) begin
      r = conclude(r, 0, 1);
    end else begin
      r.idle = m.idle + 1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma = fresh();
      mb = fresh();
    end else begin
      ma = step(ma, s, v, p, 4, 4);
      mb = step(mb, s, v, p, 2, 0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input logic [47:0] o,
                         input logic b, input logic d, input logic a, input logic t,
                         input logic [63:0] si);
    chk({tag, ".out"},       64'(o), 64'(m.out));
    chk({tag, ".busy"},      64'(b), 64'(m.busy));
    chk({tag, ".done"},      64'(d), 64'(m.done));
    chk({tag, ".accept"},    64'(a), 64'(m.accept));
    chk({tag, ".timeout"},   64'(t), 64'(m.tmo));
    chk({tag, ".stage_idx"}, si,     64'(m.stage));
  endtask

  // Every cycle, away from the rising edge.
  always @(negedge clk) begin
    cmp_dut("a", ma, ifa.out, ifa.busy, ifa.done, ifa.accept, ifa.timeout, 64'(ifa.stage_idx));
    cmp_dut("b", mb, ifb.out, ifb.busy, ifb.done, ifb.accept, ifb.timeout, 64'(ifb.stage_idx));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; s = 1'b0; v = 1'b0; p = 1'b0;
    cyc(3);
    chk("reset.a.out", 64'(ifa.out), 64'd0);
    chk("reset.a.busy", 64'(ifa.busy), 64'd0);
    chk("reset.b.stage_idx", 64'(ifb.stage_idx), 64'd0);
    rst = 1'b1;

    // check_valid in IDLE is ignored
    v = 1; p = 1; cyc(1);
    chk("idle_valid.a.busy", 64'(ifa.busy), 64'd0);
    chk("idle_valid.b.done", 64'(ifb.done), 64'd0);
    v = 0;

    // two passes: b (2 checks) accepts, a (4 checks) reaches stage 2
    s = 1; cyc(1);
    chk("start.a.busy", 64'(ifa.busy), 64'd1);
    chk("start.a.stage_idx", 64'(ifa.stage_idx), 64'd0);
    s = 0; cyc(1);
    v = 1; p = 1; cyc(2);
    chk("acc.b.done", 64'(ifb.done), 64'd1);
    chk("acc.b.out", 64'(ifb.out), 64'(ACC));
    chk("acc.b.accept", 64'(ifb.accept), 64'd1);
    chk("acc.b.busy", 64'(ifb.busy), 64'd0);
    chk("acc.a.stage_idx", 64'(ifa.stage_idx), 64'd2);
    v = 0; cyc(1);
    chk("acc_hold.b.done", 64'(ifb.done), 64'd0);
    chk("acc_hold.b.out", 64'(ifb.out), 64'(ACC));

    // fail at stage 2 on a
    v = 1; p = 0; cyc(1);
    chk("rej.a.done", 64'(ifa.done), 64'd1);
    chk("rej.a.out", 64'(ifa.out), 64'(REJ));
    chk("rej.a.accept", 64'(ifa.accept), 64'd0);
    chk("rej.a.timeout", 64'(ifa.timeout), 64'd0);
    chk("rej.a.stage_idx", 64'(ifa.stage_idx), 64'd2);
    chk("rej.b.out_held", 64'(ifb.out), 64'(ACC));

    // start in RESULT with a failing verdict alongside: verdict ignored
    s = 1; v = 1; p = 0; cyc(1);
    chk("restart.a.out", 64'(ifa.out), 64'd0);
    chk("restart.a.busy", 64'(ifa.busy), 64'd1);
    chk("restart.a.done", 64'(ifa.done), 64'd0);
    s = 0; v = 0; cyc(3);
    chk("to_pre.a.busy", 64'(ifa.busy), 64'd1);
    cyc(1);
    chk("to.a.done", 64'(ifa.done), 64'd1);
    chk("to.a.timeout", 64'(ifa.timeout), 64'd1);
    chk("to.a.out", 64'(ifa.out), 64'(REJ));
    chk("to.b.busy", 64'(ifb.busy), 64'd1);

    // pass on the expiry cycle wins, then timer restarts
    s = 1; cyc(1);
    s = 0; cyc(3);
    v = 1; p = 1; cyc(1);
    chk("exp_pass.a.stage_idx", 64'(ifa.stage_idx), 64'd1);
    chk("exp_pass.a.timeout", 64'(ifa.timeout), 64'd0);
    chk("exp_pass.a.busy", 64'(ifa.busy), 64'd1);
    v = 0; cyc(2);
    s = 1; cyc(1);
    chk("start_in_wait.a.stage_idx", 64'(ifa.stage_idx), 64'd1);
    chk("start_in_wait.a.busy", 64'(ifa.busy), 64'd1);
    s = 0; cyc(1);
    chk("to2.a.timeout", 64'(ifa.timeout), 64'd1);

    // async reset mid-WAIT at stage 1
    s = 1; cyc(1);
    s = 0; v = 1; p = 1; cyc(1);
    chk("pre_rst.a.stage_idx", 64'(ifa.stage_idx), 64'd1);
    v = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst.a.busy", 64'(ifa.busy), 64'd0);
    chk("arst.a.stage_idx", 64'(ifa.stage_idx), 64'd0);
    chk("arst.a.done", 64'(ifa.done), 64'd0);
    chk("arst.b.out", 64'(ifb.out), 64'd0);
    chk("arst.b.accept", 64'(ifb.accept), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    s = 1; cyc(1);
    chk("post_rst.a.busy", 64'(ifa.busy), 64'd1);
    chk("post_rst.a.stage_idx", 64'(ifa.stage_idx), 64'd0);
    s = 0;

    // timeout disabled on b: stays busy indefinitely
    cyc(1000);
    chk("no_to.b.busy", 64'(ifb.busy), 64'd1);
    chk("no_to.b.done", 64'(ifb.done), 64'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 4);
      p = ($urandom_range(0, 19) != 0);
      cyc(1);
    end
    s = 0; v = 0; p = 0;
    cyc(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
